// File: rtl/serializador_w.sv
// Parallel-to-serial front end for the sequence detector: takes a word over a
// valid/ready handshake and plays it out one bit per clock on w, with stall.
module serializador_w #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d, shifted;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             w_d;

  // The bit that goes on the line next always sits at the head of shreg.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    w_d     = w;
    shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
          shreg_d = data_in;
          cnt_d   = '0;
          w_d     = head(data_in);
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt == LAST) begin
            state_d = DONE;
            shreg_d = '0;
            cnt_d   = '0;
            w_d     = IDLE_LEVEL;
          end else begin
            state_d = SHIFT;
            shreg_d = shifted;
            cnt_d   = cnt + 1'b1;
            w_d     = head(shifted);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order or other processes.
  // The shift register is small datapath state, so it is reset along with the
  // control; a mid-word reset then leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      w     <= IDLE_LEVEL;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      cnt   <= cnt_d;
      w     <= w_d;
    end
  end

  // Status flags decode straight from the state register: no input reaches an
  // output without passing through a flop.
  assign load_ready = (state == IDLE);
  assign w_valid    = (state == SHIFT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_serializador_w.sv
// Bench for serializador_w: three instances (8-bit MSB-first, 8-bit LSB-first,
// 1-bit) driven together, checked every cycle against a position-based model.
module tb_serializador_w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       lv = 1'b0;
  logic       hold = 1'b0;

  logic lr_m, w_m, wv_m, busy_m, done_m;
  logic lr_l, w_l, wv_l, busy_l, done_l;
  logic lr_1, w_1, wv_1, busy_1, done_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializador_w #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .data_in(data), .load_valid(lv),
    .load_ready(lr_m), .hold(hold), .w(w_m), .w_valid(wv_m),
    .busy(busy_m), .done(done_m));

  serializador_w #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(data), .load_valid(lv),
    .load_ready(lr_l), .hold(hold), .w(w_l), .w_valid(wv_l),
    .busy(busy_l), .done(done_l));

  serializador_w #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .data_in(data[0:0]), .load_valid(lv),
    .load_ready(lr_1), .hold(hold), .w(w_1), .w_valid(wv_1),
    .busy(busy_1), .done(done_1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pos = -1 idle, 0..width-1 = index of the bit on the line, width = done.
  typedef struct {
    int          pos;
    logic [31:0] word;
  } mdl_t;

  mdl_t m_m = '{-1, 32'd0};
  mdl_t m_l = '{-1, 32'd0};
  mdl_t m_1 = '{-1, 32'd0};

  function automatic mdl_t step(input mdl_t m, input int width, input logic lv_i,
                                input logic hold_i, input logic [31:0] d);
    mdl_t n = m;
    if (m.pos < 0) begin
      if (lv_i) begin
        n.pos  = 0;
        n.word = d;
      end
    end else if (m.pos < width) begin
      if (!hold_i) n.pos = m.pos + 1;
    end else begin
      n.pos = -1;
    end
    return n;
  endfunction

  function automatic logic exp_w(input mdl_t m, input int width, input bit msb);
    if (m.pos >= 0 && m.pos < width) return m.word[msb ? width - 1 - m.pos : m.pos];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_m <= '{-1, 32'd0};
      m_l <= '{-1, 32'd0};
      m_1 <= '{-1, 32'd0};
    end else begin
      m_m <= step(m_m, 8, lv, hold, {24'd0, data});
      m_l <= step(m_l, 8, lv, hold, {24'd0, data});
      m_1 <= step(m_1, 1, lv, hold, {31'd0, data[0]});
    end
  end

  task automatic cmp(input string tag, input mdl_t m, input int width, input bit msb,
                     input logic lr, input logic wo, input logic wv,
                     input logic bz, input logic dn);
    check({tag, " w"},          wo, exp_w(m, width, msb));
    check({tag, " w_valid"},    wv, (m.pos >= 0 && m.pos < width));
    check({tag, " busy"},       bz, (m.pos >= 0));
    check({tag, " done"},       dn, (m.pos == width));
    check({tag, " load_ready"}, lr, (m.pos < 0));
  endtask

  always @(negedge clk) begin
    cmp("m", m_m, 8, 1'b1, lr_m, w_m, wv_m, busy_m, done_m);
    cmp("l", m_l, 8, 1'b0, lr_l, w_l, wv_l, busy_l, done_l);
    cmp("1", m_1, 1, 1'b1, lr_1, w_1, wv_1, busy_1, done_1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int seq1[8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
  int seq2[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
  int seq3[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int seq5[8]  = '{1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int busy_cnt;
    int done_cnt;
    int last;
    int naccept;
    logic prev_busy;

    // Reset state
    tick();
    tick();
    check("rst load_ready", lr_m, 1);
    check("rst w", w_m, 0);
    check("rst w_valid", wv_m, 0);
    check("rst busy", busy_m, 0);
    check("rst done", done_m, 0);
    #1 rst_n = 1'b1;
    tick();

    // 8'hA5 MSB-first; the 1-bit instance sends data[0]=1 at the same time
    data = 8'hA5; lv = 1'b1;
    tick();
    lv = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        check($sformatf("t1 bit%0d", k), w_m, seq1[k]);
        check($sformatf("t1 valid%0d", k), wv_m, 1);
      end
      if (k == 7) check("t1 done early", done_m, 0);
      if (k == 8) check("t1 done", done_m, 1);
      if (k == 9) begin
        check("t1 ready", lr_m, 1);
        check("t1 done drop", done_m, 0);
      end
      if (k == 0) begin
        check("t6 w", w_1, 1);
        check("t6 w_valid", wv_1, 1);
      end
      if (k == 1) begin
        check("t6 done", done_1, 1);
        check("t6 w idle", w_1, 0);
      end
      if (k == 2) begin
        check("t6 ready", lr_1, 1);
        check("t6 done drop", done_1, 0);
      end
      busy_cnt += int'(busy_m);
      tick();
    end
    check("t1 busy cycles", busy_cnt, 9);

    // 8'h01 LSB-first
    data = 8'h01; lv = 1'b1;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) check($sformatf("t2 bit%0d", k), w_l, seq2[k]);
      if (k == 7) check("t2 done early", done_l, 0);
      if (k == 8) check("t2 done", done_l, 1);
      tick();
    end

    // 8'hF0 MSB-first, hold for 3 edges while the third bit is on the line
    data = 8'hF0; lv = 1'b1;
    tick();
    lv = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      if (k < 11) check($sformatf("t3 w%0d", k), w_m, seq3[k]);
      if (k == 10) check("t3 done early", done_m, 0);
      if (k == 11) check("t3 done", done_m, 1);
      if (k == 12) check("t3 ready", lr_m, 1);
      done_cnt += int'(done_m);
      hold = (k >= 2 && k <= 4);
      tick();
    end
    hold = 1'b0;
    check("t3 done cycles", done_cnt, 1);

    // load_valid held high, data changing every cycle
    lv = 1'b1;
    last = -1;
    naccept = 0;
    prev_busy = busy_m;
    for (int c = 0; c < 35; c++) begin
      data = 8'(c * 37 + 11);
      tick();
      if (busy_m && !prev_busy) begin
        if (last >= 0) check("t4 spacing", c - last, 10);
        last = c;
        naccept++;
      end
      prev_busy = busy_m;
    end
    lv = 1'b0;
    check("t4 accepts", naccept, 4);
    repeat (12) tick();

    // Asynchronous reset during the 4th bit
    data = 8'h3C; lv = 1'b1;
    tick();
    lv = 1'b0;
    repeat (3) tick();
    check("t5 pre busy", busy_m, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5 ready", lr_m, 1);
    check("t5 w", w_m, 0);
    check("t5 w_valid", wv_m, 0);
    check("t5 busy", busy_m, 0);
    check("t5 busy l", busy_l, 0);
    done_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      done_cnt += int'(done_m);
    end
    #1 rst_n = 1'b1;
    tick();
    done_cnt += int'(done_m);
    check("t5 no done", done_cnt, 0);
    data = 8'h81; lv = 1'b1;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) check($sformatf("t5 bit%0d", k), w_m, seq5[k]);
      if (k == 8) check("t5 done", done_m, 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
